// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-cache port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      STORE   = 2'd2,
      LD_KILL = 2'd3
   } arb_state_e;

   localparam int unsigned STARVE_MAX_DEF = 4;
   localparam int unsigned STARVE_CNT_W   = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Store-starvation counter: counts load grants issued while a store waits.
module arb_starve_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic str_req_i,
   input  logic ld_grant_i,
   input  logic st_grant_i,
   output logic starve_hit_o
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_MAX);

   logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

   // Saturate instead of wrapping so a long load burst cannot hide a waiting store.
   always_comb begin
      cnt_d = cnt_q;
      if (!str_req_i || st_grant_i) begin
         cnt_d = '0;
      end else if (ld_grant_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve_hit_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-cache port arbiter between the load unit and the store-queue drain.
// Optional store anti-starvation logic is enabled with `define MEM_ARB_STARVE_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 16,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_req,
   input  logic [AW-1:0] addr_ld,
   input  logic          str_req,
   input  logic [AW-1:0] addr_str,
   input  logic [DW-1:0] data_ca,
   input  logic          stll_str,
   input  logic          flsh,
   input  logic          done,
   output logic          ld_grnt,
   output logic          str_grnt,
   output logic          cache_req,
   output logic          cache_we,
   output logic [AW-1:0] cache_addr,
   output logic [DW-1:0] cache_wdata,
   output logic          ld_vld
);

   arb_state_e    state_q, state_d;
   arb_state_e    arb_pick;
   logic          arb_go;
   logic          starve_hit;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          ld_vld_q, ld_vld_d;

   // A flush blocks new loads, which also covers flush coinciding with done.
   always_comb begin
      arb_pick = IDLE;
      if (str_req && (stll_str || starve_hit)) begin
         arb_pick = STORE;
      end else if (ld_req && !flsh) begin
         arb_pick = LOAD;
      end else if (str_req) begin
         arb_pick = STORE;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ld_vld_d = 1'b0;
      arb_go   = 1'b0;
      case (state_q)
         IDLE:    arb_go = 1'b1;
         LOAD: begin
            if (done) begin
               ld_vld_d = !flsh;
               arb_go   = 1'b1;
            end else if (flsh) begin
               state_d = LD_KILL;
            end
         end
         STORE:   arb_go = done;
         LD_KILL: if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (arb_go) begin
         state_d = arb_pick;
         if (arb_pick == LOAD) begin
            addr_d  = addr_ld;
            wdata_d = '0;
         end else if (arb_pick == STORE) begin
            addr_d  = addr_str;
            wdata_d = data_ca;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         ld_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ld_vld_q <= ld_vld_d;
      end
   end

`ifdef MEM_ARB_STARVE_EN
   logic ld_issue, st_issue;

   assign ld_issue = arb_go && (arb_pick == LOAD);
   assign st_issue = arb_go && (arb_pick == STORE);

   arb_starve_cnt #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve_cnt (
      .clk_i       (clk),
      .rst_ni      (rst),
      .str_req_i   (str_req),
      .ld_grant_i  (ld_issue),
      .st_grant_i  (st_issue),
      .starve_hit_o(starve_hit)
   );
`else
   assign starve_hit = 1'b0;
`endif

   assign ld_grnt     = (state_q == LOAD);
   assign str_grnt    = (state_q == STORE);
   assign cache_req   = (state_q != IDLE);
   assign cache_we    = (state_q == STORE);
   assign cache_addr  = addr_q;
   assign cache_wdata = wdata_q;
   assign ld_vld      = ld_vld_q;

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) !(ld_grnt && str_grnt));
   a_starve_range: assert property (@(posedge clk) (STARVE_MAX >= 1) && (STARVE_MAX <= 15));

endmodule
